relu_lane_arbiter: RTL
======================

RELU_LANE_ARBITER -- requirements
Module: relu_lane_arbiter

Interface
REQ-001 SHALL have parameter N_LANES, default 4, the number of accumulator lanes sharing one relu_activation instance.
REQ-002 SHALL have parameter ACC_W, default 64, the signed accumulator/data width, which matches relu_activation ACC_W.
REQ-003 SHALL have parameter LANE_W, default $clog2(N_LANES) (minimum 1), the lane-tag width.
REQ-004 SHALL use one clock and an asynchronous active-low reset, with ports listed first:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  arbitration enable; a 1->0 transition starts the drain
- lane_mask  in  N_LANES  per-lane grant enable; sampled every cycle
- req_data  in  N_LANES x ACC_W  signed lane operands
- req_valid  in  N_LANES  lane valid
- req_ready  out  N_LANES  lane accepted this cycle
- relu_in_data  out  ACC_W  to relu_activation in_data
- relu_in_valid  out  1  to relu_activation in_valid
- relu_out_data  in  ACC_W  from relu_activation out_data
- relu_out_valid  in  1  from relu_activation out_valid
- relu_out_ready  out  1  to relu_activation out_ready
- res_data  out  ACC_W  activated result
- res_lane  out  LANE_W  originating lane of res_data
- res_valid  out  1  result valid
- res_ready  in  1  downstream ready
- busy  out  1  high in RUN or DRAIN
- drained  out  1  one-cycle pulse on the DRAIN->IDLE transition

Function
REQ-005 SHALL define relu_accept = relu_in_valid && (relu_out_ready || !relu_out_valid), which mirrors the relu_activation acceptance rule.
REQ-006 SHALL implement states IDLE, RUN and DRAIN:
- IDLE->RUN when enable=1.
- RUN->DRAIN when enable=0.
- DRAIN->IDLE when the tag FIFO is empty and relu_out_valid=0.
- DRAIN->RUN when enable=1 is seen before the drain completes.
REQ-007 SHALL grant only in RUN, among lanes with req_valid && lane_mask, using round-robin order that starts at rr_ptr and increases in lane index with wrap.
REQ-008 SHALL make the grant combinational:
- relu_in_valid=1 when an eligible lane exists and the tag FIFO is not full.
- relu_in_data = req_data of the granted lane.
- req_ready[g] = relu_accept for the granted lane g; all other bits are 0.
REQ-009 SHALL set rr_ptr to (g+1) mod N_LANES only on a cycle with relu_accept; rr_ptr is unchanged otherwise.
REQ-010 SHALL push g into a 2-entry lane-tag FIFO on relu_accept.
REQ-011 SHALL pass relu_out_data to res_data combinationally, with:
- res_valid = relu_out_valid.
- relu_out_ready = res_ready.
- res_lane = tag FIFO head.
REQ-012 SHALL pop the tag FIFO on relu_out_valid && res_ready.
REQ-013 SHALL process a simultaneous push and pop in the same cycle with no change in occupancy.
REQ-014 SHALL block grants when the tag FIFO is full (relu_in_valid=0).
REQ-015 SHALL have zero added latency: a lane beat accepted at edge N appears on res_* after edge N (the relu register stage only).
REQ-016 SHALL keep results in acceptance order, with no reordering across lanes.
REQ-017 SHALL ignore a lane with lane_mask=0 even if its req_valid=1; a masked lane never receives req_ready.
REQ-018 SHALL not change the result path when lane_mask or enable changes; in-flight beats always complete.

Reset
REQ-019 SHALL, while rst_n=0, asynchronously force:
- state=IDLE, rr_ptr=0, tag FIFO empty.
- req_ready=0, relu_in_valid=0, busy=0, drained=0.
REQ-020 SHALL, on reset assertion mid-operation, discard in-flight tags without emitting drained; relu_activation shares rst_n and is cleared at the same time.

Structure
REQ-021 SHALL place the state enum (IDLE/RUN/DRAIN) and the lane-tag width function in the shared package bsnc_pkg.
REQ-022 SHALL instantiate exactly one sub-module, rr_arbiter (N-way round-robin grant given a request vector and a pointer), reusable by other shared-resource schedulers.
REQ-023 SHALL not instantiate relu_activation; it is connected beside it at the top level.

Verification
REQ-024 SHALL cover fairness: with N_LANES=4, ACC_W=16 and all lanes always valid (lane0=-5, lane1=7, lane2=0, lane3=-32768), res_lane sequence 0,1,2,3,0,... and res_data sequence 0,7,0,0,... are required.
REQ-025 SHALL cover masking: with lane_mask=4'b0101 and all lanes valid, only lanes 0 and 2 alternate and req_ready[1]=req_ready[3]=0 throughout.
REQ-026 SHALL cover backpressure: with res_ready low for 5 cycles while lane1 streams 10..14, the tag FIFO holds ≤2, no beat is lost, and the results are 10..14 with lane 1 in order.
REQ-027 SHALL cover drain: enable dropped with 2 beats in flight gives busy=1 until both outputs are consumed, then drained pulses exactly 1 cycle and there are no grants after the drop.
REQ-028 SHALL cover reset mid-stream: rst_n asserted while res_valid=1 gives all outputs at reset values immediately, no drained pulse, and after release rr_ptr=0 so lane 0 is granted first.
REQ-029 SHALL run a scoreboard that checks, per beat, res_data = max(in,0) and res_lane = source lane, under random valid/ready/mask for at least 1000 beats with zero mismatches.

Source files
------------

// File: rtl/bsnc_pkg.sv
// Shared types and helpers for the lane-arbitration schedulers.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package bsnc_pkg;

    // Scheduler control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_t;

    // Depth of the in-flight lane-tag FIFO.
    localparam int TAG_DEPTH = 2;

    // Lane-tag width for n lanes, never narrower than one bit.
    function automatic int lane_w(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin grant: first requester at or after ptr, wrapping upward.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is consumed.
//
// Ports:
//   req      in   N       request vector
//   ptr      in   IDX_W   highest-priority index (must be < N)
//   gnt_vld  out  1       some request is granted
//   gnt_idx  out  IDX_W   granted index (0 when gnt_vld=0)
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             gnt_vld,
    output logic [IDX_W-1:0] gnt_idx
);

    // Rotating the doubled vector right by ptr puts lane ptr at bit 0, so a
    // plain lowest-set-bit search yields round-robin order.
    logic [2*N-1:0] req_dbl;
    logic [2*N-1:0] req_rot;

    assign req_dbl = {req, req};
    assign req_rot = req_dbl >> ptr;

    always_comb begin
        logic [IDX_W:0] sum;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        sum     = '0;
        for (int j = 0; j < N; j++) begin
            if (!gnt_vld && req_rot[j]) begin
                gnt_vld = 1'b1;
                sum     = {1'b0, ptr} + (IDX_W+1)'(j);
                if (sum >= (IDX_W+1)'(N)) begin
                    sum = sum - (IDX_W+1)'(N);
                end
                gnt_idx = sum[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/relu_lane_arbiter.sv
// Shares one relu_activation stage among N_LANES accumulator lanes, round-robin, tagging each beat with its lane.
// Latency: zero added; a beat accepted at edge N appears on res_* after edge N (the relu register only).
// Backpressure: res_ready drives relu_out_ready; grants stall when relu is blocked or the 2-entry tag FIFO is full.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   enable                          run enable; falling edge starts a drain
//   lane_mask, req_data/valid/ready per-lane request side
//   relu_in_*, relu_out_*           connection to the neighbouring relu_activation
//   res_data/lane/valid/ready       activated result with originating lane
//   busy, drained                   RUN/DRAIN indicator, drain-complete pulse
module relu_lane_arbiter
    import bsnc_pkg::*;
#(
    parameter int N_LANES = 4,
    parameter int ACC_W   = 64,
    parameter int LANE_W  = lane_w(N_LANES)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            enable,
    input  logic [N_LANES-1:0]              lane_mask,
    input  logic [N_LANES-1:0][ACC_W-1:0]   req_data,
    input  logic [N_LANES-1:0]              req_valid,
    output logic [N_LANES-1:0]              req_ready,
    output logic [ACC_W-1:0]                relu_in_data,
    output logic                            relu_in_valid,
    input  logic [ACC_W-1:0]                relu_out_data,
    input  logic                            relu_out_valid,
    output logic                            relu_out_ready,
    output logic [ACC_W-1:0]                res_data,
    output logic [LANE_W-1:0]               res_lane,
    output logic                            res_valid,
    input  logic                            res_ready,
    output logic                            busy,
    output logic                            drained
);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [LANE_W-1:0] rr_ptr;
    logic [N_LANES-1:0] eligible;
    logic              gnt_vld;
    logic [LANE_W-1:0] gnt_idx;
    logic              grant_en;
    logic              relu_accept;
    logic              drain_done;

    logic [LANE_W-1:0] tag_mem [TAG_DEPTH];
    logic              tag_wr_ptr;
    logic              tag_rd_ptr;
    logic [1:0]        tag_cnt;
    logic              tag_full;
    logic              tag_empty;
    logic              tag_pop;

    assign eligible = req_valid & lane_mask;

    rr_arbiter #(
        .N     (N_LANES),
        .IDX_W (LANE_W)
    ) u_rr (
        .req     (eligible),
        .ptr     (rr_ptr),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    // ---------------- control FSM ----------------
    assign drain_done = tag_empty && !relu_out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (enable) state_nxt = ST_RUN;
            ST_RUN:   if (!enable) state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                // A re-enable wins over completion: resume without a drained pulse.
                if (enable) begin
                    state_nxt = ST_RUN;
                end else if (drain_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != ST_IDLE);
        // Qualifying with enable stops grants in the very cycle enable drops,
        // before the state register has moved to DRAIN.
        grant_en = (state == ST_RUN) && enable;
        drained  = (state == ST_DRAIN) && !enable && drain_done;
    end

    // ---------------- grant / data path ----------------
    always_comb begin
        relu_in_valid = grant_en && gnt_vld && !tag_full;
        relu_accept   = relu_in_valid && (relu_out_ready || !relu_out_valid);
        relu_in_data  = req_data[gnt_idx];
        req_ready     = '0;
        if (relu_accept) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign relu_out_ready = res_ready;
    assign res_data       = relu_out_data;
    assign res_valid      = relu_out_valid;
    assign res_lane       = tag_mem[tag_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (relu_accept) begin
            rr_ptr <= (gnt_idx == LANE_W'(N_LANES - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // ---------------- lane-tag FIFO ----------------
    assign tag_full  = (tag_cnt == 2'(TAG_DEPTH));
    assign tag_empty = (tag_cnt == 2'd0);
    assign tag_pop   = relu_out_valid && res_ready && !tag_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_wr_ptr <= 1'b0;
            tag_rd_ptr <= 1'b0;
            tag_cnt    <= 2'd0;
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_mem[i] <= '0;
            end
        end else begin
            if (relu_accept) begin
                tag_mem[tag_wr_ptr] <= gnt_idx;
                tag_wr_ptr          <= ~tag_wr_ptr;
            end
            if (tag_pop) begin
                tag_rd_ptr <= ~tag_rd_ptr;
            end
            case ({relu_accept, tag_pop})
                2'b10:   tag_cnt <= tag_cnt + 2'd1;
                2'b01:   tag_cnt <= tag_cnt - 2'd1;
                default: tag_cnt <= tag_cnt;
            endcase
        end
    end

endmodule
